// File: rtl/my_cpu16v1.sv
// my_cpu16v1: two-state 16-bit register-to-register CPU with internal byte memory and 8x16 register file
//   Ports: CK (rising-edge clock), RST_N (asynchronous active-low reset)
//   Optional: define CPU16_HALT_EN to make IR[15:8]==8'hFF halt the CPU until reset (net halted)
module my_cpu16v1_mem #(
  parameter int MEM_BYTES = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [7:0]    rd0,
  output logic [7:0]    rd1
);
  logic [7:0] mem [0:MEM_BYTES-1];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
endmodule

module my_cpu16v1_regs (
  input  logic        clk,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [15:0] wd,
  input  logic [2:0]  ra0,
  input  logic [2:0]  ra1,
  output logic [15:0] rd0,
  output logic [15:0] rd1
);
  logic [15:0] registers [0:7];
  always_ff @(posedge clk)
    if (we) registers[wa] <= wd;
  assign rd0 = registers[ra0];
  assign rd1 = registers[ra1];
endmodule

module my_cpu16v1 #(
  parameter int MEM_BYTES = 256
) (
  input logic CK,
  input logic RST_N
);
  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t state, state_nx;
  logic [15:0] PC, IR, A, B, R, pc1;
  logic [3:0]  Func;
  logic [16:0] sum;
  logic [7:0]  b0, b1;
  logic Cout, S_SUB, S_FAS, IsAND, IsOR, IsXOR, IsNOT, valid, halt_op, we, carry, unused_bits;
  assign pc1 = PC + 16'd1;
  my_cpu16v1_mem #(.MEM_BYTES(MEM_BYTES), .AW(AW)) memory1 (
    .clk(CK), .we(1'b0), .wa('0), .wd('0),
    .ra0(AW'(PC % MEM_BYTES)), .ra1(AW'(pc1 % MEM_BYTES)), .rd0(b0), .rd1(b1)
  );
  my_cpu16v1_regs register1 (
    .clk(CK), .we(we), .wa(IR[10:8]), .wd(R),
    .ra0(IR[10:8]), .ra1(IR[2:0]), .rd0(A), .rd1(B)
  );
  assign Func  = IR[7:4];
  assign S_FAS = Func[2:0] == 3'b010;
  assign S_SUB = S_FAS & ~Func[3];
  assign IsAND = Func == 4'b1100;
  assign IsOR  = Func == 4'b1110;
  assign IsXOR = Func == 4'b1101;
  assign IsNOT = Func == 4'b1111;
  assign valid = S_FAS | IsAND | IsOR | IsXOR | IsNOT;
  // subtraction as A + ~B + 1 so bit 16 is the no-borrow flag
  assign sum   = {1'b0, A} + {1'b0, S_SUB ? ~B : B} + {16'd0, S_SUB};
  assign carry = sum[16];
  assign R = S_FAS ? sum[15:0] : IsAND ? A & B : IsOR ? A | B : IsXOR ? A ^ B : IsNOT ? ~B : '0;
`ifdef CPU16_HALT_EN
  logic halted;
  assign halt_op = IR[15:8] == 8'hFF;
  assign halted  = state == HALT;
  assign unused_bits = ^{IR[3], halted};
`else
  assign halt_op = 1'b0;
  assign unused_bits = ^{IR[15:11], IR[3]};
`endif
  assign we = state == EXEC && valid && !halt_op;
  always_comb
    state_nx = state == FETCH ? EXEC : (state == EXEC && !halt_op) ? FETCH : HALT;
  always_ff @(posedge CK or negedge RST_N)
    if (!RST_N) begin
      state <= FETCH;
      PC    <= '0;
      IR    <= '0;
      Cout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH) begin
        IR <= {b0, b1};
        PC <= PC + 16'd2;
      end
      if (we && S_FAS) Cout <= carry;
    end
endmodule

// File: tb/tb_my_cpu16v1.sv
// tb_my_cpu16v1: directed plus random instruction checking of my_cpu16v1 against an instruction-level model
module tb_my_cpu16v1;
  logic CK = 1'b0;
  logic RST_N = 1'b0;
  my_cpu16v1 dut (.CK(CK), .RST_N(RST_N));
  always #5 CK = ~CK;

  int total = 0;
  int bad = 0;
  logic [15:0] m_pc;
  logic        m_cout;
  logic [15:0] m_reg [8];
  logic [7:0]  m_mem [256];
  logic [15:0] m_r;
  logic [5:0]  m_strb;
  logic [3:0]  ops [6] = '{4'b1010, 4'b0010, 4'b1100, 4'b1110, 4'b1101, 4'b1111};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input int i, input logic [15:0] v);
    m_reg[i] = v;
    dut.register1.registers[i] = v;
  endtask

  task automatic put(input logic [15:0] w);
    int a0, a1;
    a0 = int'(m_pc) % 256;
    a1 = int'(m_pc + 16'd1) % 256;
    m_mem[a0] = w[15:8];
    m_mem[a1] = w[7:0];
    dut.memory1.mem[a0] = w[15:8];
    dut.memory1.mem[a1] = w[7:0];
  endtask

  // strobe order: {S_SUB, S_FAS, IsAND, IsOR, IsXOR, IsNOT}
  task automatic model(input logic [15:0] w);
    int a, b;
    a = int'(m_reg[w[10:8]]);
    b = int'(m_reg[w[2:0]]);
    case (w[7:4])
      4'b1010: begin m_r = 16'(a + b); m_cout = (a + b) > 65535; m_strb = 6'b010000; end
      4'b0010: begin m_r = 16'(a - b); m_cout = a >= b;          m_strb = 6'b110000; end
      4'b1100: begin m_r = 16'(a & b); m_strb = 6'b001000; end
      4'b1110: begin m_r = 16'(a | b); m_strb = 6'b000100; end
      4'b1101: begin m_r = 16'(a ^ b); m_strb = 6'b000010; end
      4'b1111: begin m_r = ~16'(b);    m_strb = 6'b000001; end
      default: begin m_r = 16'd0;      m_strb = 6'b000000; end
    endcase
    if (m_strb != 6'd0) m_reg[w[10:8]] = m_r;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".pc"}, dut.PC, m_pc);
    chk({tag, ".cout"}, dut.Cout, m_cout);
    for (int i = 0; i < 8; i++) chk($sformatf("%s.r%0d", tag, i), dut.register1.registers[i], m_reg[i]);
  endtask

  task automatic step(input logic [15:0] w, input string tag);
    put(w);
    m_pc = m_pc + 16'd2;
    model(w);
    @(posedge CK);
    @(negedge CK);
    chk({tag, ".ir"}, dut.IR, w);
    chk({tag, ".pc_f"}, dut.PC, m_pc);
    chk({tag, ".strb"}, {dut.S_SUB, dut.S_FAS, dut.IsAND, dut.IsOR, dut.IsXOR, dut.IsNOT}, m_strb);
    chk({tag, ".alu"}, dut.R, m_r);
    @(posedge CK);
    @(negedge CK);
    check_state(tag);
  endtask

  initial begin
    logic [15:0] w;
    m_pc = 16'd0;
    m_cout = 1'b0;
    for (int i = 0; i < 8; i++) set_reg(i, 16'd0);
    #2;
    chk("rst.pc", dut.PC, 16'd0);
    chk("rst.ir", dut.IR, 16'd0);
    chk("rst.cout", dut.Cout, 1'b0);
    set_reg(0, 16'd65280);
    set_reg(1, 16'd257);
    @(negedge CK);
    @(negedge CK);
    RST_N = 1'b1;
    step(16'h00A1, "add");
    set_reg(2, 16'd16);
    set_reg(3, 16'd9);
    step(16'h0223, "sub");
    set_reg(1, 16'd257);
    set_reg(4, 16'd255);
    step(16'h01C4, "and");
    set_reg(5, 16'd43520);
    set_reg(6, 16'd21760);
    step(16'h05E6, "or");
    set_reg(2, 16'd3);
    set_reg(3, 16'd5);
    step(16'h0223, "sub_borrow");
    set_reg(7, 16'h1234);
    set_reg(3, 16'hFF0F);
    step(16'h07D3, "xor");
    set_reg(1, 16'h00F0);
    step(16'h06F1, "not");
    set_reg(3, 16'h8001);
    step(16'h03A3, "add_rd_eq_rs");
    step(16'h0404, "nop");
    step(16'hF8A1, "hi_ignored");
    step(16'h01AA, "ir3_ignored");
    put(16'h00A1);
    set_reg(0, 16'h1111);
    set_reg(1, 16'h2222);
    @(posedge CK);
    @(negedge CK);
    RST_N = 1'b0;
    m_pc = 16'd0;
    m_cout = 1'b0;
    #1;
    chk("rst_exec.ir", dut.IR, 16'd0);
    @(posedge CK);
    @(negedge CK);
    check_state("rst_exec");
    RST_N = 1'b1;
`ifdef CPU16_HALT_EN
    put(16'hFF00);
    m_pc = m_pc + 16'd2;
    repeat (11) @(posedge CK);
    @(negedge CK);
    chk("halt.flag", dut.halted, 1'b1);
    check_state("halt");
    RST_N = 1'b0;
    m_pc = 16'd0;
    m_cout = 1'b0;
    @(negedge CK);
    RST_N = 1'b1;
`endif
    for (int n = 0; n < 140; n++) begin
      if ($urandom_range(0, 2) == 0) set_reg($urandom_range(0, 7), 16'($urandom));
      w = 16'($urandom);
      if ($urandom_range(0, 3) != 0) w[7:4] = ops[$urandom_range(0, 5)];
      if (w[15:8] == 8'hFF) w[15] = 1'b0;
      step(w, $sformatf("rnd%0d", n));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
